inst_loader: RTL and testbench

- Boot-time instruction loader sitting upstream of the core's instruction memory.
- Receives a byte stream framed as: length, words, checksum. Assembles 16-bit instructions and writes them sequentially into instruction memory from address 0.
- Holds the core in reset until a complete, checksum-valid image is loaded.
- Replaces the static file preload for hardware bring-up.

---
 rtl/inst_loader.sv | 155 +++++++++++++++
 tb/tb_inst_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader: receives a length/words/checksum byte stream,
// writes 16-bit instructions sequentially into instruction memory from
// address 0, and releases the core from reset only after the image checksum
// has been verified.
module inst_loader #(
  parameter int p_INST_NUM = 1024,
  parameter int p_ADDR_W   = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_byte_valid,
  input  logic [7:0]          i_byte,
  output logic                o_byte_ready,
  input  logic                i_restart,
  output logic                o_mem_we,
  output logic [p_ADDR_W-1:0] o_mem_addr,
  output logic [15:0]         o_mem_wdata,
  output logic                o_core_rst,
  output logic                o_done,
  output logic                o_err
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM_HI,
    S_CSUM_LO,
    S_DONE,
    S_ERR
  } state_t;

  // Largest image length that fits in instruction memory.
  localparam logic [15:0] c_MAX_LEN = 16'(p_INST_NUM);

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;          // high byte of LEN, a word or CSUM
  logic [15:0]         len_q, len_d;        // image length N in words
  logic [15:0]         idx_q, idx_d;        // words written so far; wide enough to reach N without wrapping
  logic [15:0]         sum_q, sum_d;        // running checksum, modulo 2^16
  logic                mem_we_q, mem_we_d;
  logic [p_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic [15:0] byte_pair;
  logic [15:0] idx_inc;

  // Stream is always accepted except while parked in a terminal state.
  assign o_byte_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept       = i_byte_valid && o_byte_ready;
  assign byte_pair    = {hi_q, i_byte};
  assign idx_inc      = idx_q + 16'd1;

  // Next-state, datapath and write-strobe computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = byte_pair;
          idx_d = '0;
          sum_d = '0;
          if (byte_pair > c_MAX_LEN)  state_d = S_ERR;
          else if (byte_pair == '0)   state_d = S_CSUM_HI;
          else                        state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[p_ADDR_W-1:0];
          mem_wdata_d = byte_pair;
          sum_d       = sum_q + byte_pair;
          idx_d       = idx_inc;
          state_d     = (idx_inc == len_q) ? S_CSUM_HI : S_DATA_HI;
        end
      end
      S_CSUM_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_CSUM_LO;
        end
      end
      S_CSUM_LO: begin
        if (accept) begin
          state_d = (byte_pair == sum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (i_restart) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_LEN_HI;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_LEN_HI;
      hi_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_done      = (state_q == S_DONE);
  assign o_err       = (state_q == S_ERR);
  assign o_core_rst  = (state_q != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: drives framed byte streams and checks
// memory writes, status outputs and core reset against hand-computed values.
module tb_inst_loader;

  localparam int p_INST_NUM = 1024;
  localparam int p_ADDR_W   = 10;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_byte_valid;
  logic [7:0]          i_byte;
  logic                o_byte_ready;
  logic                i_restart;
  logic                o_mem_we;
  logic [p_ADDR_W-1:0] o_mem_addr;
  logic [15:0]         o_mem_wdata;
  logic                o_core_rst;
  logic                o_done;
  logic                o_err;

  inst_loader #(
    .p_INST_NUM(p_INST_NUM),
    .p_ADDR_W  (p_ADDR_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_byte_valid(i_byte_valid),
    .i_byte      (i_byte),
    .o_byte_ready(o_byte_ready),
    .i_restart   (i_restart),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_core_rst  (o_core_rst),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [25:0] wr_log[$];   // observed writes {addr, data}
  logic [15:0] words_q[$];  // payload words of the frame under test

  // Record every write strobe away from the active edge.
  always @(negedge i_clk) begin
    if (o_mem_we) wr_log.push_back({o_mem_addr, o_mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte after an optional idle gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
    i_byte       = b;
    i_byte_valid = 1'b1;
    n = 0;
    while (!o_byte_ready && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_byte_ready) check("ready_timeout", {31'd0, o_byte_ready}, 32'd1);
    else begin
      @(posedge i_clk);
      #1;
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    send_byte(w[15:8], $urandom_range(0, max_gap));
    send_byte(w[7:0],  $urandom_range(0, max_gap));
  endtask

  // LEN, every word in words_q, then CSUM; max_gap > 0 inserts random stalls.
  task automatic send_frame(input logic [15:0] len, input logic [15:0] csum, input int max_gap);
    wr_log.delete();
    send_word(len, max_gap);
    foreach (words_q[i]) send_word(words_q[i], max_gap);
    send_word(csum, max_gap);
  endtask

  // Compare the write log with words_q written at ascending addresses.
  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_log.size(), words_q.size());
    foreach (words_q[i]) begin
      if (i < wr_log.size()) begin
        check({tag, "_addr"}, {22'd0, wr_log[i][25:16]}, i);
        check({tag, "_data"}, {16'd0, wr_log[i][15:0]}, {16'd0, words_q[i]});
      end
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic crst,
                              input logic rdy);
    check({tag, "_done"},  {31'd0, o_done},       {31'd0, done});
    check({tag, "_err"},   {31'd0, o_err},        {31'd0, err});
    check({tag, "_crst"},  {31'd0, o_core_rst},   {31'd0, crst});
    check({tag, "_ready"}, {31'd0, o_byte_ready}, {31'd0, rdy});
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(posedge i_clk);
    #1;
    i_restart = 1'b0;
  endtask

  task automatic load_nominal();
    words_q = '{16'h1234, 16'hABCD, 16'h0001};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    i_restart    = 1'b0;
    #1;
    check("rst_we",    {31'd0, o_mem_we}, 32'd0);
    check("rst_addr",  {22'd0, o_mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, o_mem_wdata}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Nominal load: 0x1234 + 0xABCD + 0x0001 = 0xBE02.
    load_nominal();
    send_frame(16'h0003, 16'hBE02, 0);
    check_status("nom", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("nom");
    check("nom_hold_addr",  {22'd0, o_mem_addr}, 32'd2);
    check("nom_hold_wdata", {16'd0, o_mem_wdata}, 32'h0001);

    // Restart from DONE re-arms the loader.
    pulse_restart();
    check_status("rs1", 1'b0, 1'b0, 1'b1, 1'b1);

    // Bad checksum: writes still happen, then ERR.
    send_frame(16'h0003, 16'hBE03, 0);
    check_status("bad", 1'b0, 1'b1, 1'b1, 1'b0);
    check_writes("bad");
    pulse_restart();
    check_status("rs2", 1'b0, 1'b0, 1'b1, 1'b1);

    // Length overflow: 1025 > 1024 goes to ERR after the second byte.
    wr_log.delete();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check_status("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    check("ovf_nwr", wr_log.size(), 32'd0);
    pulse_restart();

    // Zero-length image.
    words_q.delete();
    send_frame(16'h0000, 16'h0000, 0);
    check_status("zero", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("zero");
    pulse_restart();

    // Checksum wrap: 0xFFFF + 0x0002 = 0x0001 modulo 2^16.
    words_q = '{16'hFFFF, 16'h0002};
    send_frame(16'h0002, 16'h0001, 0);
    check_status("wrap", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("wrap");
    pulse_restart();

    // Nominal frame with random stalls between bytes.
    load_nominal();
    send_frame(16'h0003, 16'hBE02, 3);
    check_status("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("stall");
    pulse_restart();
    check_status("rs3", 1'b0, 1'b0, 1'b1, 1'b1);

    // Second frame after restart: 0x0F0F + 0x1111 = 0x2020.
    words_q = '{16'h0F0F, 16'h1111};
    send_frame(16'h0002, 16'h2020, 0);
    check_status("f2", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("f2");
    pulse_restart();

    // Full-depth image: words 0..1023, sum 523776 mod 65536 = 0xFE00.
    words_q.delete();
    for (int i = 0; i < p_INST_NUM; i++) words_q.push_back(16'(i));
    send_frame(16'(p_INST_NUM), 16'hFE00, 0);
    check_status("full", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("full");
    check("full_last_addr", {22'd0, o_mem_addr}, 32'd1023);
    pulse_restart();

    // Async reset mid-frame: LEN plus three data bytes, then drop reset off-edge.
    wr_log.delete();
    send_word(16'h0003, 0);
    send_word(16'h1234, 0);
    send_byte(8'hAB, 0);
    check("mid_wdata_pre", {16'd0, o_mem_wdata}, 32'h1234);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_we",    {31'd0, o_mem_we}, 32'd0);
    check("arst_addr",  {22'd0, o_mem_addr}, 32'd0);
    check("arst_wdata", {16'd0, o_mem_wdata}, 32'd0);
    check_status("arst", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    load_nominal();
    send_frame(16'h0003, 16'hBE02, 0);
    check_status("post", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
